// File: rtl/tdc_encoder_mc.sv
// Multi-channel thermometer TDC encoder: round-robin shared 2-stage encoder.
// Optional per-channel error counters via `define TDC_ENC_ERRCNT_EN.
module tdc_encoder_mc #(
   parameter  int N_CH   = 4,
   parameter  int RAW_W  = 63,
   parameter  int CNT_W  = 3,
   parameter  int CODE_W = 10,
   parameter  int LVL_W  = 3,
   localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_CH-1:0]         in_valid,
   input  logic [N_CH*RAW_W-1:0]   in_raw,
   input  logic [N_CH*CNT_W-1:0]   in_cnt_a,
   input  logic [N_CH*CNT_W-1:0]   in_cnt_b,
   input  logic [LVL_W-1:0]        level,
   input  logic [CODE_W-1:0]       offset,
   input  logic                    sel_raw,
   input  logic                    clr_ovf,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [CH_W-1:0]         out_ch,
   output logic [CODE_W-1:0]       out_code,
   output logic                    out_err,
   output logic [N_CH-1:0]         ovf_sticky
`ifdef TDC_ENC_ERRCNT_EN
   ,
   output logic [N_CH*8-1:0]       err_cnt
`endif
);

   localparam int FW = $clog2(RAW_W + 1);

   logic [RAW_W-1:0] holdRaw [N_CH];
   logic [CNT_W-1:0] holdA   [N_CH];
   logic [CNT_W-1:0] holdB   [N_CH];
   logic [N_CH-1:0]  pending;
   logic [CH_W-1:0]  rrPtr;

   logic             s1Valid;
   logic [FW-1:0]    s1Fine;
   logic [FW-1:0]    s1Trans;
   logic [CH_W-1:0]  s1Ch;
   logic [CNT_W-1:0] s1CntA;
   logic [CNT_W-1:0] s1CntB;

   logic             s2Adv;
   logic             grantValid;
   logic             grantEn;
   logic [CH_W-1:0]  grantCh;
   logic [N_CH-1:0]  grantMask;
   logic [N_CH-1:0]  capEn;
   logic [N_CH-1:0]  ovfEv;
   logic [RAW_W-1:0] selRaw;
   logic [FW-1:0]    fineC;
   logic [FW-1:0]    transC;
   int               idx;
   logic [CH_W-1:0]  idxW;

   // S1 only moves when S2 can take its word, so a stall freezes grants
   assign s2Adv = !out_valid || out_ready;

   always_comb begin
      grantValid = 1'b0;
      grantCh    = '0;
      idx        = 0;
      idxW       = '0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         idx = int'(rrPtr) + k;
         if (idx >= N_CH) idx = idx - N_CH;
         idxW = CH_W'(idx);
         if (pending[idxW]) begin
            grantValid = 1'b1;
            grantCh    = idxW;
         end
      end
   end

   assign grantEn   = grantValid && s2Adv;
   assign grantMask = grantEn ? (N_CH'(1) << grantCh) : '0;
   // a grant frees the slot in the same cycle, so a new strobe is not lost
   assign capEn     = in_valid & (~pending | grantMask);
   assign ovfEv     = in_valid & pending & ~grantMask;
   assign selRaw    = holdRaw[grantCh];

   always_comb begin
      fineC  = '0;
      transC = '0;
      for (int i = 0; i < RAW_W; i++)
         fineC = fineC + FW'(selRaw[i]);
      for (int i = 0; i < RAW_W - 1; i++)
         transC = transC + FW'(selRaw[i] ^ selRaw[i+1]);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int c = 0; c < N_CH; c++) begin
            holdRaw[c] <= '0;
            holdA[c]   <= '0;
            holdB[c]   <= '0;
         end
         pending    <= '0;
         ovf_sticky <= '0;
         rrPtr      <= '0;
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            if (capEn[c]) begin
               holdRaw[c] <= in_raw[c*RAW_W +: RAW_W];
               holdA[c]   <= in_cnt_a[c*CNT_W +: CNT_W];
               holdB[c]   <= in_cnt_b[c*CNT_W +: CNT_W];
            end
         end
         pending    <= (pending & ~grantMask) | capEn;
         ovf_sticky <= (clr_ovf ? '0 : ovf_sticky) | ovfEv;
         if (grantEn)
            rrPtr <= (int'(grantCh) == N_CH - 1) ? '0 : grantCh + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1Valid <= 1'b0;
         s1Fine  <= '0;
         s1Trans <= '0;
         s1Ch    <= '0;
         s1CntA  <= '0;
         s1CntB  <= '0;
      end else if (s2Adv) begin
         s1Valid <= grantValid;
         if (grantValid) begin
            s1Fine  <= fineC;
            s1Trans <= transC;
            s1Ch    <= grantCh;
            s1CntA  <= holdA[grantCh];
            s1CntB  <= holdB[grantCh];
         end
      end
   end

   logic [CNT_W-1:0]    coarse;
   logic [31:0]         corrWide;
   logic [CNT_W+FW-1:0] rawCat;
   logic [CODE_W-1:0]   codeC;
   logic                errC;

   // low fine counts trust copy B, high fine counts trust copy A
   always_comb begin
      coarse   = (int'(s1Fine) < RAW_W / 2) ? s1CntB : s1CntA;
      corrWide = 32'(coarse) * 32'(RAW_W) + 32'(s1Fine) - 32'(offset);
      rawCat   = {coarse, s1Fine};
      codeC    = sel_raw ? CODE_W'(rawCat) : corrWide[CODE_W-1:0];
      errC     = 32'(s1Trans) > (32'(level) + 32'd1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_ch    <= '0;
         out_code  <= '0;
         out_err   <= 1'b0;
      end else if (s2Adv) begin
         out_valid <= s1Valid;
         if (s1Valid) begin
            out_ch   <= s1Ch;
            out_code <= codeC;
            out_err  <= errC;
         end
      end
   end

`ifdef TDC_ENC_ERRCNT_EN
   logic [7:0] errCnt [N_CH];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int c = 0; c < N_CH; c++) errCnt[c] <= '0;
      end else if (clr_ovf) begin
         for (int c = 0; c < N_CH; c++) errCnt[c] <= '0;
      end else if (out_valid && out_ready && out_err) begin
         if (errCnt[out_ch] != 8'hFF)
            errCnt[out_ch] <= errCnt[out_ch] + 8'd1;
      end
   end

   always_comb begin
      err_cnt = '0;
      for (int c = 0; c < N_CH; c++) err_cnt[c*8 +: 8] = errCnt[c];
   end
`endif

endmodule

// File: tb/tb_tdc_encoder_mc.sv
// Scoreboard bench for tdc_encoder_mc with directed vectors.
module tb_tdc_encoder_mc;

   localparam int N_CH   = 4;
   localparam int RAW_W  = 63;
   localparam int CNT_W  = 3;
   localparam int CODE_W = 10;
   localparam int LVL_W  = 3;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [N_CH-1:0]       in_valid;
   logic [N_CH*RAW_W-1:0] in_raw;
   logic [N_CH*CNT_W-1:0] in_cnt_a;
   logic [N_CH*CNT_W-1:0] in_cnt_b;
   logic [LVL_W-1:0]      level;
   logic [CODE_W-1:0]     offset;
   logic                  sel_raw;
   logic                  clr_ovf;
   logic                  out_valid;
   logic                  out_ready;
   logic [1:0]            out_ch;
   logic [CODE_W-1:0]     out_code;
   logic                  out_err;
   logic [N_CH-1:0]       ovf_sticky;
`ifdef TDC_ENC_ERRCNT_EN
   logic [N_CH*8-1:0]     err_cnt;
`endif

   tdc_encoder_mc #(
      .N_CH(N_CH), .RAW_W(RAW_W), .CNT_W(CNT_W),
      .CODE_W(CODE_W), .LVL_W(LVL_W)
   ) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid),
      .in_raw(in_raw), .in_cnt_a(in_cnt_a), .in_cnt_b(in_cnt_b),
      .level(level), .offset(offset), .sel_raw(sel_raw),
      .clr_ovf(clr_ovf), .out_valid(out_valid),
      .out_ready(out_ready), .out_ch(out_ch),
      .out_code(out_code), .out_err(out_err),
      .ovf_sticky(ovf_sticky)
`ifdef TDC_ENC_ERRCNT_EN
      , .err_cnt(err_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int ch;
      int code;
      int err;
      int id;
   } exp_t;

   exp_t q[$];
   int   nChecks = 0;
   int   nFails  = 0;
   int   nPushed = 0;

   task automatic chk(input string name, input int act, input int req);
      nChecks++;
      if (act != req) begin
         nFails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   function automatic logic [RAW_W-1:0] th(input int n);
      logic [RAW_W-1:0] v;
      v = '0;
      for (int i = 0; i < n; i++) v[i] = 1'b1;
      return v;
   endfunction

   task automatic expectW(input int ch, input int code, input int err);
      exp_t e;
      e.ch = ch; e.code = code; e.err = err; e.id = nPushed;
      nPushed++;
      q.push_back(e);
   endtask

   task automatic stage(input int c, input logic [RAW_W-1:0] r,
                        input logic [CNT_W-1:0] a,
                        input logic [CNT_W-1:0] b);
      in_valid[c] = 1'b1;
      in_raw[c*RAW_W +: RAW_W] = r;
      in_cnt_a[c*CNT_W +: CNT_W] = a;
      in_cnt_b[c*CNT_W +: CNT_W] = b;
   endtask

   task automatic fire();
      @(posedge clk);
      #1 in_valid = '0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      if (q.size() != 0) begin
         nChecks++;
         nFails++;
         $display("FAIL drain: %0d words outstanding, expected 0",
                  q.size());
         q.delete();
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   // monitor: compare every transferred word against the queue head
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset && out_valid && out_ready) begin
            nChecks++;
            if (q.size() == 0) begin
               nFails++;
               $display("FAIL unexpected word: got ch=%0d code=%0d err=%0d, expected none",
                        out_ch, out_code, out_err);
            end else begin
               e = q.pop_front();
               if (int'(out_ch) != e.ch || int'(out_code) != e.code ||
                   int'(out_err) != e.err) begin
                  nFails++;
                  $display("FAIL word%0d: got ch=%0d code=%0d err=%0d, expected ch=%0d code=%0d err=%0d",
                           e.id, out_ch, out_code, out_err,
                           e.ch, e.code, e.err);
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [RAW_W-1:0] bub;
      reset     = 1'b0;
      in_valid  = '0;
      in_raw    = '0;
      in_cnt_a  = '0;
      in_cnt_b  = '0;
      level     = 3'd1;
      offset    = '0;
      sel_raw   = 1'b0;
      clr_ovf   = 1'b0;
      out_ready = 1'b1;
      bub       = th(20);
      bub[25]   = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_ch",    int'(out_ch),    0);
      chk("rst_code",  int'(out_code),  0);
      chk("rst_err",   int'(out_err),   0);
      chk("rst_ovf",   int'(ovf_sticky), 0);
      @(posedge clk);
      #1 reset = 1'b1;

      // basic encode and two-cycle latency
      stage(0, th(20), 3'd3, 3'd3);
      expectW(0, 209, 0);
      fire();
      chk("lat_t0", int'(out_valid), 0);
      @(posedge clk); #1;
      chk("lat_t1", int'(out_valid), 0);
      @(posedge clk); #1;
      chk("lat_t2", int'(out_valid), 1);
      drain();

      // coarse copy A, offset, raw mode
      offset = 10'd15;
      stage(1, th(63), 3'd5, 3'd2);
      expectW(1, 363, 0);
      fire();
      drain();
      sel_raw = 1'b1;
      stage(1, th(63), 3'd5, 3'd2);
      expectW(1, 383, 0);
      fire();
      drain();
      sel_raw = 1'b0;
      offset  = '0;

      // bubble tolerance
      stage(2, bub, 3'd3, 3'd3);
      expectW(2, 210, 1);
      fire();
      drain();
      level = 3'd2;
      stage(2, bub, 3'd3, 3'd3);
      expectW(2, 210, 0);
      fire();
      drain();
      level = 3'd1;

      // pointer to 0, then two full bursts
      stage(3, th(1), 3'd0, 3'd0);
      expectW(3, 1, 0);
      fire();
      drain();
      for (int b = 0; b < 2; b++) begin
         stage(0, th(8),  3'd1, 3'd1);
         stage(1, th(16), 3'd2, 3'd2);
         stage(2, th(32), 3'd3, 3'd3);
         stage(3, th(48), 3'd4, 3'd4);
         expectW(0, 71, 0);
         expectW(1, 142, 0);
         expectW(2, 221, 0);
         expectW(3, 300, 0);
         fire();
         drain();
      end
      stage(1, th(2), 3'd0, 3'd0);
      expectW(1, 2, 0);
      fire();
      drain();
      stage(1, th(4), 3'd0, 3'd0);
      stage(3, th(3), 3'd0, 3'd0);
      expectW(3, 3, 0);
      expectW(1, 4, 0);
      fire();
      drain();

      // stall, overflow, sticky clear
      out_ready = 1'b0;
      stage(0, th(10), 3'd1, 3'd1);
      stage(1, th(40), 3'd2, 3'd6);
      expectW(0, 73, 0);
      expectW(1, 166, 0);
      fire();
      @(posedge clk); #1;
      @(posedge clk); #1;
      stage(1, th(5), 3'd7, 3'd4);
      expectW(1, 257, 0);
      fire();
      chk("stall_code0", int'(out_code), 73);
      stage(1, '0, 3'd0, 3'd0);
      fire();
      chk("stall_code1", int'(out_code), 73);
      repeat (3) begin
         @(posedge clk); #1;
         chk("stall_valid", int'(out_valid), 1);
         chk("stall_ch",    int'(out_ch),    0);
         chk("stall_code",  int'(out_code),  73);
      end
      chk("ovf_set", int'(ovf_sticky), 2);
      out_ready = 1'b1;
      drain();
      chk("ovf_keep", int'(ovf_sticky), 2);
      clr_ovf = 1'b1;
      @(posedge clk);
      #1 clr_ovf = 1'b0;
      chk("ovf_clr", int'(ovf_sticky), 0);

      // reset with words in flight
      out_ready = 1'b0;
      stage(0, th(10), 3'd1, 3'd1);
      stage(1, th(11), 3'd1, 3'd1);
      stage(2, th(12), 3'd1, 3'd1);
      fire();
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("inflight_valid", int'(out_valid), 1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("async_rst_valid", int'(out_valid), 0);
      @(posedge clk);
      #1 reset = 1'b1;
      out_ready = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         chk("post_rst_idle", int'(out_valid), 0);
      end
      chk("post_rst_ovf", int'(ovf_sticky), 0);

`ifdef TDC_ENC_ERRCNT_EN
      level = 3'd1;
      for (int n = 0; n < 300; n++) begin
         stage(0, bub, 3'd3, 3'd3);
         expectW(0, 210, 1);
         fire();
         @(posedge clk); #1;
      end
      drain();
      chk("errcnt_sat", int'(err_cnt[7:0]), 255);
      chk("errcnt_other", int'(err_cnt[31:8]), 0);
      clr_ovf = 1'b1;
      @(posedge clk);
      #1 clr_ovf = 1'b0;
      chk("errcnt_clr", int'(err_cnt[7:0]), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/tdc_encoder_mc.md
Name: tdc_encoder_mc

Overview:
Multi-channel, parametrised second-generation TDC encoder. It accepts thermometer-coded delay-line snapshots plus two coarse-counter copies from N_CH TDC channels. A single shared 2-stage pipelined encoder serves the channels round-robin. Encoded codes leave through a valid/ready stream tagged with the channel index, in front of the pixel readout buffer.

Parameters:
N_CH, 4, number of TDC channels (1..16)
RAW_W, 63, thermometer taps per channel (>=4)
CNT_W, 3, coarse counter width
CODE_W, 10, output code width
LVL_W, 3, bubble-tolerance level width

Ports:
clk  in  1  single clock, all logic rising-edge
reset  in  1  asynchronous active-low reset
in_valid  in  N_CH  per-channel capture strobe, one cycle
in_raw  in  N_CH*RAW_W  thermometer data, channel c at [c*RAW_W +: RAW_W]
in_cnt_a  in  N_CH*CNT_W  coarse counter copy A
in_cnt_b  in  N_CH*CNT_W  coarse counter copy B
level  in  LVL_W  tolerated excess transitions
offset  in  CODE_W  subtracted from code
sel_raw  in  1  1: output uncorrected {coarse,fine}
clr_ovf  in  1  synchronous clear of ovf_sticky
out_valid  out  1  output word valid
out_ready  in  1  downstream accept
out_ch  out  clog2(N_CH) (min 1)  channel index
out_code  out  CODE_W  encoded time
out_err  out  1  bubble error flag
ovf_sticky  out  N_CH  per-channel capture overflow

Behaviour:
- Reset: all holding registers, pending bits, pipeline valids, out_valid, out_ch, out_code, out_err and ovf_sticky = 0. The round-robin pointer resets to channel 0.
- Capture: when in_valid[c]=1 and pending[c]=0, latch raw, cnt_a and cnt_b for channel c and set pending[c]=1.
- Overflow: when in_valid[c]=1 and pending[c]=1, drop the new data, keep the old data, and set ovf_sticky[c]=1.
- clr_ovf=1 clears ovf_sticky. If an overflow event occurs in the same cycle, set wins.
- Arbitration: when stage S1 can advance, grant the first pending channel at or after the round-robin pointer, wrapping. On grant, move that channel's data into S1, clear pending[c], and set the pointer to c+1 mod N_CH.
  - Capture and grant of the same channel in the same cycle: the grant takes the old data and pending stays 1 with the new data. This is not an overflow.
- S1 registers, for the granted channel:
  - fine = popcount(raw), width clog2(RAW_W+1).
  - trans = number of i in 0..RAW_W-2 with raw[i] != raw[i+1].
  - ch, cnt_a, cnt_b.
- S2, the output register:
  - coarse = cnt_b if fine < RAW_W/2 (integer division), else cnt_a.
  - Corrected code = (coarse*RAW_W + fine - offset) mod 2^CODE_W.
  - With sel_raw=1: code = {coarse, fine} zero-extended or truncated (LSBs kept) to CODE_W, with no offset applied.
  - out_err = 1 if trans > level+1, else 0. With trans=0 (all zeros or all ones), out_err = 0.
- Handshake and stall:
  - A word transfers when out_valid=1 and out_ready=1.
  - While out_valid=1 and out_ready=0: out_ch, out_code and out_err stay stable, S1 holds, and no grant is issued.
  - A pipeline bubble is filled whenever the downstream stage is empty or transferring. Throughput is 1 word per cycle.
- Latency: capture edge T, grant at T+1 (S1 loaded), out_valid at edge T+2, assuming an empty pipeline and out_ready=1.
- Configuration inputs level, offset and sel_raw are sampled in S2. Changing them mid-stream affects only words entering S2 afterwards.
- Reset mid-operation clears all in-flight words. Nothing is emitted after reset release until a new capture.

Optional Feature:
TDC_ENC_ERRCNT_EN
- Defined: adds output err_cnt, N_CH*8 bits. Per channel, an 8-bit counter increments on each transferred word of that channel with out_err=1 and saturates at 255. Reset and clr_ovf both clear it.
- Undefined: no err_cnt port and no counter logic.

Test Plan:
1. Defaults; ch0 raw = 20 LSB ones, cnt_a=3, cnt_b=3, offset=0, level=1 -> 2 cycles after capture: out_valid=1, out_ch=0, out_code=209, out_err=0.
2. Ch1 raw = 63 ones, cnt_a=5, cnt_b=2, offset=15 -> fine=63 selects cnt_a, out_code=315+63-15=363, out_err=0. Then sel_raw=1, same raw data -> out_code={3'd5, 6'd63}=0x17F.
3. Ch2 raw = ones at bits 0..19 and bit 25 (trans=3), level=1 -> out_code=3*63+21=210 with cnt=3, out_err=1. Same raw data with level=2 -> out_err=0.
4. All 4 channels strobe in the same cycle, out_ready=1 -> 4 consecutive words, out_ch=0,1,2,3. Next simultaneous burst after the pointer is at 0 -> again 0,1,2,3. Then, with the pointer at 2, set only ch1 and ch3 pending -> order 3,1.
5. out_ready=0 for 5 cycles with ch0 and ch1 captured, then a second ch1 strobe -> out_valid held with a stable word, ovf_sticky[1]=1 (and ovf_sticky[0]=1 if ch0 is re-strobed). out_ready=1 -> words ch0 then ch1 carrying the original data. clr_ovf -> ovf_sticky=0.
6. Deassert reset while words are in S1 and S2 -> out_valid=0 immediately and no words emitted afterwards. With TDC_ENC_ERRCNT_EN, 300 error words on ch0 -> err_cnt[7:0]=255.
